// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: load-use stalls, branch flushes, dmem waits.
// Define PIPE_PERF_CNT_EN to build the STALL_CNT/FLUSH_CNT performance counters (tied to zero otherwise).
module pipeline_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  RS1_ID,
  input  logic [4:0]  RS2_ID,
  input  logic        USE_RS1_ID,
  input  logic        USE_RS2_ID,
  input  logic [4:0]  RD_DE,
  input  logic [1:0]  MemRead_DE,
  input  logic        BR_TAKEN_E,
  input  logic        DMEM_REQ_M,
  input  logic        DMEM_ACK,
  output logic        PC_EN,
  output logic        PC_SEL,
  output logic        FD_EN,
  output logic        DE_EN,
  output logic        EM_EN,
  output logic        MW_EN,
  output logic        FD_FLUSH,
  output logic        DE_FLUSH,
  output logic        MW_FLUSH,
  output logic        ERR,
  output logic [31:0] STALL_CNT,
  output logic [31:0] FLUSH_CNT
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;
  logic       lu, ms;
  logic       br_flush, lu_bubble;

  assign lu = (MemRead_DE != 2'b00) && (RD_DE != 5'd0) &&
              ((USE_RS1_ID && (RS1_ID == RD_DE)) || (USE_RS2_ID && (RS2_ID == RD_DE)));
  assign ms = DMEM_REQ_M && !DMEM_ACK;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    PC_EN      = 1'b1;
    PC_SEL     = 1'b0;
    FD_EN      = 1'b1;
    DE_EN      = 1'b1;
    EM_EN      = 1'b1;
    MW_EN      = 1'b1;
    FD_FLUSH   = 1'b0;
    DE_FLUSH   = 1'b0;
    MW_FLUSH   = 1'b0;
    br_flush   = 1'b0;
    lu_bubble  = 1'b0;
    case (state_q)
      RUN, LU_STALL: begin
        state_d = RUN;
        if (ms) begin
          {PC_EN, FD_EN, DE_EN, EM_EN} = 4'b0000;
          MW_FLUSH   = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else if (BR_TAKEN_E) begin
          br_flush = 1'b1;
        end else if (lu && (state_q == RUN)) begin
          // In LU_STALL the ID/EX slot is already a bubble, so no re-stall
          lu_bubble = 1'b1;
          state_d   = LU_STALL;
        end
      end
      MEM_WAIT: begin
        if (!DMEM_ACK) begin
          {PC_EN, FD_EN, DE_EN, EM_EN} = 4'b0000;
          MW_FLUSH   = 1'b1;
          wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
          // ERR rises together with wait_cnt reaching MAX_WAIT
          if (wait_cnt_d == MAX_WAIT_C) err_d = 1'b1;
        end else begin
          wait_cnt_d = 8'd0;
          state_d    = RUN;
          if (BR_TAKEN_E) begin
            br_flush = 1'b1;
          end else if (lu) begin
            lu_bubble = 1'b1;
            state_d   = LU_STALL;
          end
        end
      end
      default: state_d = RUN;
    endcase
    if (br_flush) begin
      PC_SEL   = 1'b1;
      FD_FLUSH = 1'b1;
      DE_FLUSH = 1'b1;
    end
    if (lu_bubble) begin
      PC_EN    = 1'b0;
      FD_EN    = 1'b0;
      DE_FLUSH = 1'b1;
    end
    if (RST) begin
      {PC_EN, PC_SEL, FD_EN, DE_EN, EM_EN, MW_EN} = 6'b000000;
      {FD_FLUSH, DE_FLUSH, MW_FLUSH}              = 3'b000;
      br_flush  = 1'b0;
      lu_bubble = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign ERR = err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (PC_EN ? 32'd0 : 32'd1);
    flush_cnt_d = flush_cnt_q;
    if (br_flush)       flush_cnt_d = flush_cnt_q + 32'd2;
    else if (lu_bubble) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`else
  assign STALL_CNT = 32'h0;
  assign FLUSH_CNT = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MAX_WAIT=4); control outputs checked as one packed vector.
module tb_pipeline_ctrl;
  logic        CLK, RST;
  logic [4:0]  RS1_ID, RS2_ID, RD_DE;
  logic        USE_RS1_ID, USE_RS2_ID;
  logic [1:0]  MemRead_DE;
  logic        BR_TAKEN_E, DMEM_REQ_M, DMEM_ACK;
  logic        PC_EN, PC_SEL, FD_EN, DE_EN, EM_EN, MW_EN;
  logic        FD_FLUSH, DE_FLUSH, MW_FLUSH, ERR;
  logic [31:0] STALL_CNT, FLUSH_CNT;

  int n_chk = 0;
  int n_err = 0;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {PC_EN,PC_SEL,FD_EN,DE_EN,EM_EN,MW_EN,FD_FLUSH,DE_FLUSH,MW_FLUSH,ERR}
  localparam logic [9:0] C_DEF = 10'b1_0_1_1_1_1_0_0_0_0;
  localparam logic [9:0] C_LU  = 10'b0_0_0_1_1_1_0_1_0_0;
  localparam logic [9:0] C_BR  = 10'b1_1_1_1_1_1_1_1_0_0;
  localparam logic [9:0] C_MS  = 10'b0_0_0_0_0_1_0_0_1_0;
  localparam logic [9:0] C_RST = 10'b0;
  localparam logic [9:0] C_ERR = 10'b0_0_0_0_0_0_0_0_0_1;

  logic [9:0] ctl;
  assign ctl = {PC_EN, PC_SEL, FD_EN, DE_EN, EM_EN, MW_EN, FD_FLUSH, DE_FLUSH, MW_FLUSH, ERR};

  pipeline_ctrl #(.MAX_WAIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .USE_RS1_ID(USE_RS1_ID), .USE_RS2_ID(USE_RS2_ID),
    .RD_DE(RD_DE), .MemRead_DE(MemRead_DE),
    .BR_TAKEN_E(BR_TAKEN_E), .DMEM_REQ_M(DMEM_REQ_M), .DMEM_ACK(DMEM_ACK),
    .PC_EN(PC_EN), .PC_SEL(PC_SEL),
    .FD_EN(FD_EN), .DE_EN(DE_EN), .EM_EN(EM_EN), .MW_EN(MW_EN),
    .FD_FLUSH(FD_FLUSH), .DE_FLUSH(DE_FLUSH), .MW_FLUSH(MW_FLUSH),
    .ERR(ERR), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pc(input int v);
    return PERF ? 32'(v) : 32'h0;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic [1:0] mr,
                     input logic br, input logic req, input logic ack);
    RS1_ID = rs1; USE_RS1_ID = u1; RS2_ID = rs2; USE_RS2_ID = u2;
    RD_DE = rd; MemRead_DE = mr; BR_TAKEN_E = br; DMEM_REQ_M = req; DMEM_ACK = ack;
    #1;
  endtask

  initial begin
    RST = 1'b1;
    drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    #1;
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_stall", STALL_CNT, 32'h0);
    chk("rst_flush", FLUSH_CNT, 32'h0);

    cyc(); RST = 1'b0;
    drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);          chk("idle", 32'(ctl), 32'(C_DEF));

    // load-use on rs1, then suppressed in LU_STALL, then stalls again from RUN
    cyc(); drv(5, 1, 0, 0, 5, 2'b01, 0, 0, 0);   chk("lu_rs1", 32'(ctl), 32'(C_LU));
    cyc(); drv(5, 1, 0, 0, 5, 2'b01, 0, 0, 0);   chk("lu_stall_st", 32'(ctl), 32'(C_DEF));
    cyc(); drv(5, 1, 0, 0, 5, 2'b01, 0, 0, 0);   chk("lu_run_again", 32'(ctl), 32'(C_LU));
    chk("lu_stall_cnt", STALL_CNT, pc(1));
    chk("lu_flush_cnt", FLUSH_CNT, pc(1));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);   chk("lu_clear", 32'(ctl), 32'(C_DEF));

    cyc(); drv(0, 1, 0, 0, 0, 2'b01, 0, 0, 0);   chk("x0_nostall", 32'(ctl), 32'(C_DEF));
    cyc(); drv(3, 1, 7, 0, 7, 2'b10, 0, 0, 0);   chk("rs2_unused", 32'(ctl), 32'(C_DEF));
    cyc(); drv(3, 1, 7, 1, 7, 2'b10, 0, 0, 0);   chk("lu_rs2", 32'(ctl), 32'(C_LU));

    // taken branch in LU_STALL and in RUN with coincident load-use
    cyc(); drv(3, 1, 7, 1, 7, 2'b10, 1, 0, 0);   chk("br_in_lus", 32'(ctl), 32'(C_BR));
    cyc(); drv(3, 1, 7, 1, 7, 2'b10, 1, 0, 0);   chk("br_over_lu", 32'(ctl), 32'(C_BR));
    cyc(); drv(3, 1, 7, 1, 7, 2'b10, 0, 0, 0);   chk("br_stays_run", 32'(ctl), 32'(C_LU));
    chk("br_stall_cnt", STALL_CNT, pc(3));
    chk("br_flush_cnt", FLUSH_CNT, pc(7));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);   chk("br_clear", 32'(ctl), 32'(C_DEF));
    chk("br_flush_cnt2", FLUSH_CNT, pc(8));

    // memory wait: same-cycle ack, then 3 wait cycles
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 1);   chk("ms_fast_ack", 32'(ctl), 32'(C_DEF));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);   chk("ms_w1", 32'(ctl), 32'(C_MS));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);   chk("ms_w2", 32'(ctl), 32'(C_MS));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);   chk("ms_w3", 32'(ctl), 32'(C_MS));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 1);   chk("ms_ack", 32'(ctl), 32'(C_DEF));
    chk("ms_stall_cnt", STALL_CNT, pc(7));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);   chk("ms_idle", 32'(ctl), 32'(C_DEF));

    // timeout: ack withheld 6 cycles, ERR visible after the 4th
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);   chk("to_w1", 32'(ctl), 32'(C_MS));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);   chk("to_w2", 32'(ctl), 32'(C_MS));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);   chk("to_w3", 32'(ctl), 32'(C_MS));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);   chk("to_w4", 32'(ctl), 32'(C_MS));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);   chk("to_w5_err", 32'(ctl), 32'(C_MS | C_ERR));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);   chk("to_w6_err", 32'(ctl), 32'(C_MS | C_ERR));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 1);   chk("to_ack_err", 32'(ctl), 32'(C_DEF | C_ERR));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);   chk("to_sticky", 32'(ctl), 32'(C_DEF | C_ERR));
    chk("to_stall_cnt", STALL_CNT, pc(13));

    // async reset clears ERR and counters mid-cycle
    RST = 1'b1; #1;
    chk("arst_ctl", 32'(ctl), 32'(C_RST));
    chk("arst_stall", STALL_CNT, 32'h0);
    cyc(); RST = 1'b0;
    drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);          chk("arst_release", 32'(ctl), 32'(C_DEF));

    // reset in the middle of a memory wait
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);   chk("mwr_w1", 32'(ctl), 32'(C_MS));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 1, 0);   chk("mwr_w2", 32'(ctl), 32'(C_MS));
    RST = 1'b1; #1;
    chk("mwr_rst", 32'(ctl), 32'(C_RST));
    cyc(); chk("mwr_rst_hold", 32'(ctl), 32'(C_RST));
    RST = 1'b0;
    drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);          chk("mwr_run", 32'(ctl), 32'(C_DEF));
    cyc(); drv(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);   chk("mwr_run2", 32'(ctl), 32'(C_DEF));
    chk("mwr_stall_cnt", STALL_CNT, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
